// File: rtl/seq_cover_counter.sv
// Free-running step counter with a shift-register sequence matcher for cover work.
// Define SEQ_COVER_SVA_EN to compile in the cover/assert checker; the default build omits it.
module seq_cover_counter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SEQ_LEN = 3,
  parameter int HIT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] start_val,
  output logic [WIDTH-1:0] x,
  output logic             hit,
  output logic             covered,
  output logic [HIT_W-1:0] hit_count
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [HIT_W-1:0] CNT_MAX = {HIT_W{1'b1}};

  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   w_x_next;
  logic [SEQ_LEN-1:0] r_m;
  logic [SEQ_LEN-1:0] w_m_next;
  logic [SEQ_LEN-1:0] w_e;
  logic               r_covered;
  logic [HIT_W-1:0]   r_hit_count;
  logic [HIT_W-1:0]   w_count_next;
  logic               w_hit_next;

  // Element k compares the live counter against the live start value plus its fixed offset.
  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_elem
    assign w_e[k] = (r_x == (start_val + WIDTH'(k * STEP)));
  end

  // Stage k survives only if stage k-1 matched on the previous clock.
  always_comb begin
    w_m_next    = '0;
    w_m_next[0] = w_e[0];
    for (int i = 1; i < SEQ_LEN; i++) begin
      w_m_next[i] = w_e[i] & r_m[i-1];
    end
  end

  assign w_hit_next = w_m_next[SEQ_LEN-1];

  // Counter next value: load wins over enable.
  always_comb begin
    w_x_next = r_x;
    if (load) begin
      w_x_next = load_val;
    end else if (en) begin
      w_x_next = r_x + STEP_W;
    end else begin
      w_x_next = r_x;
    end
  end

  // Hit counter saturates at all-ones.
  always_comb begin
    w_count_next = r_hit_count;
    if (w_hit_next && (r_hit_count != CNT_MAX)) begin
      w_count_next = r_hit_count + HIT_W'(1);
    end else begin
      w_count_next = r_hit_count;
    end
  end

  // All state registers; covered and hit_count update on the same edge that raises hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_m         <= '0;
      r_covered   <= 1'b0;
      r_hit_count <= '0;
    end else begin
      r_x         <= w_x_next;
      r_m         <= w_m_next;
      r_covered   <= r_covered | w_hit_next;
      r_hit_count <= w_count_next;
    end
  end

  assign x         = r_x;
  assign hit       = r_m[SEQ_LEN-1];
  assign covered   = r_covered;
  assign hit_count = r_hit_count;

`ifdef SEQ_COVER_SVA_EN
  seq_cover_counter_sva #(
    .WIDTH(WIDTH), .STEP(STEP), .SEQ_LEN(SEQ_LEN), .HIT_W(HIT_W)
  ) u_sva (
    .clk(clk), .rst_n(rst_n), .x(r_x), .start_val(start_val),
    .hit(hit), .covered(r_covered), .hit_count(r_hit_count)
  );
`else
  // Default build carries no checker.
`endif

endmodule

`ifdef SEQ_COVER_SVA_EN
// Cover and safety properties observing the counter from outside its state.
module seq_cover_counter_sva #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SEQ_LEN = 3,
  parameter int HIT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  input logic [WIDTH-1:0] x,
  input logic [WIDTH-1:0] start_val,
  input logic             hit,
  input logic             covered,
  input logic [HIT_W-1:0] hit_count
);

  localparam logic [WIDTH-1:0] OFF1     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] OFF2     = WIDTH'(2 * STEP);
  localparam logic [WIDTH-1:0] LAST_OFF = WIDTH'((SEQ_LEN - 1) * STEP);

  if (SEQ_LEN == 3) begin : g_cover
    c_seq: cover property (@(posedge clk) disable iff (!rst_n)
      (x == start_val) ##1 (x == start_val + OFF1) ##1 (x == start_val + OFF2));
  end

  a_hit_last: assert property (@(posedge clk) disable iff (!rst_n)
    hit |-> ($past(x) == ($past(start_val) + LAST_OFF)));

  a_cov_mono: assert property (@(posedge clk) disable iff (!rst_n)
    $past(covered) |-> covered);

  a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
    hit_count >= $past(hit_count));

endmodule
`endif

// File: tb/tb_seq_cover_counter.sv
// Directed self-checking bench: WIDTH=8, STEP=1, SEQ_LEN=3; a second HIT_W=2 instance checks saturation.
module tb_seq_cover_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] start_val;
  logic [7:0] x;
  logic       hit;
  logic       covered;
  logic [7:0] hit_count;
  logic [7:0] x2;
  logic       hit2;
  logic       covered2;
  logic [1:0] hit_count2;

  int n_total = 0;
  int n_pass  = 0;

  seq_cover_counter #(.WIDTH(8), .STEP(1), .SEQ_LEN(3), .HIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .start_val(start_val), .x(x), .hit(hit), .covered(covered), .hit_count(hit_count)
  );

  seq_cover_counter #(.WIDTH(8), .STEP(1), .SEQ_LEN(3), .HIT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .start_val(start_val), .x(x2), .hit(hit2), .covered(covered2), .hit_count(hit_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = 8'd0; start_val = 8'd0;
    #12;
    n_total++;
    if ({x, hit, covered, hit_count} !== 19'd0)
      $display("FAIL reset_state: got x=%0d hit=%0b cov=%0b cnt=%0d, want all 0", x, hit, covered, hit_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    start_val = 8'd3;
    en = 1'b1;
    for (int c = 1; c <= 255; c++) begin
      tick();
      n_total++;
      if (x !== 8'(c) || hit !== (c == 6))
        $display("FAIL basic_c%0d: got x=%0d hit=%0b, want x=%0d hit=%0b", c, x, hit, c, (c == 6));
      else n_pass++;
    end
    n_total++;
    if (covered !== 1'b1 || hit_count !== 8'd1)
      $display("FAIL basic_final: got cov=%0b cnt=%0d, want cov=1 cnt=1", covered, hit_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic exp_hit;
    do_reset();
    start_val = 8'd254;
    en = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      tick();
      exp_hit = (c >= 257) && (x == 8'd1);
      if (c >= 250) begin
        n_total++;
        if (x !== 8'(c) || hit !== exp_hit)
          $display("FAIL wrap_c%0d: got x=%0d hit=%0b, want x=%0d hit=%0b", c, x, hit, 8'(c), exp_hit);
        else n_pass++;
      end
    end
    n_total++;
    if (hit_count !== 8'd2 || covered !== 1'b1)
      $display("FAIL wrap_count: got cnt=%0d cov=%0b, want cnt=2 cov=1", hit_count, covered);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] exp_x [0:9];
    exp_x = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    do_reset();
    start_val = 8'd2;
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      en = (c != 2);
      n_total++;
      if (x !== exp_x[c] || hit !== 1'b0 || covered !== 1'b0)
        $display("FAIL stall_c%0d: got x=%0d hit=%0b cov=%0b, want x=%0d hit=0 cov=0", c, x, hit, covered, exp_x[c]);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    do_reset();
    start_val = 8'd10;
    en = 1'b1;
    for (int c = 0; c < 11; c++) tick();
    load = 1'b1; load_val = 8'd40;
    tick();
    load = 1'b0;
    n_total++;
    if (x !== 8'd40) $display("FAIL load_40: got x=%0d, want 40", x);
    else n_pass++;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_total++;
      if (x !== 8'(40 + c) || hit !== 1'b0)
        $display("FAIL load_broken_c%0d: got x=%0d hit=%0b, want x=%0d hit=0", c, x, hit, 40 + c);
      else n_pass++;
    end
    load = 1'b1; load_val = 8'd10;
    tick();
    load = 1'b0;
    for (int c = 11; c <= 14; c++) begin
      tick();
      n_total++;
      if (x !== 8'(c) || hit !== (c == 13))
        $display("FAIL load_resume_x%0d: got x=%0d hit=%0b, want x=%0d hit=%0b", c, x, hit, c, (c == 13));
      else n_pass++;
    end
    n_total++;
    if (covered !== 1'b1 || hit_count !== 8'd1)
      $display("FAIL load_final: got cov=%0b cnt=%0d, want cov=1 cnt=1", covered, hit_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_val = 8'd3;
    en = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    n_total++;
    if (covered !== 1'b1 || hit_count !== 8'd1)
      $display("FAIL arst_pre: got cov=%0b cnt=%0d, want cov=1 cnt=1", covered, hit_count);
    else n_pass++;
    load = 1'b1; load_val = 8'd0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_total++;
    if (x !== 8'd4) $display("FAIL arst_at4: got x=%0d, want 4", x);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({x, hit, covered, hit_count} !== 19'd0)
      $display("FAIL arst_immediate: got x=%0d hit=%0b cov=%0b cnt=%0d, want all 0", x, hit, covered, hit_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_total++;
      if (x !== 8'(c) || hit !== (c == 6))
        $display("FAIL arst_after_c%0d: got x=%0d hit=%0b, want x=%0d hit=%0b", c, x, hit, c, (c == 6));
      else n_pass++;
    end
    n_total++;
    if (hit_count !== 8'd1) $display("FAIL arst_after_cnt: got %0d, want 1", hit_count);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int lap;
    logic [1:0] exp_sat;
    do_reset();
    start_val = 8'd0;
    en = 1'b1;
    lap = 0;
    for (int c = 1; c <= 5 * 256; c++) begin
      tick();
      if (x == 8'd4) begin
        lap++;
        exp_sat = (lap >= 3) ? 2'd3 : 2'(lap);
        n_total++;
        if (hit_count2 !== exp_sat || covered2 !== 1'b1 || hit_count !== 8'(lap))
          $display("FAIL sat_lap%0d: got cnt2=%0d cov2=%0b cnt=%0d, want cnt2=%0d cov2=1 cnt=%0d",
                   lap, hit_count2, covered2, hit_count, exp_sat, lap);
        else n_pass++;
      end
    end
    n_total++;
    if (lap !== 5) $display("FAIL sat_laps: got %0d laps, want 5", lap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_load();
    test_async_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
